// File: rtl/conv_core.sv
// conv_core: streaming 8-channel 3x3 convolution with fused ReLU, 2x2
// max-pool and requantise. It first loads CH*9 signed weights, then
// consumes a zero-padded image as 4-row x 2-column strips. It emits one
// pooled 8-bit result for each 2x2 block of convolution outputs.
//
// Handshake: i_valid qualifies a beat. There is no ready, so every cycle
// with i_valid=1 (outside reset) is consumed. o_valid is a one-cycle pulse;
// o_data holds its value until the next pulse.
module conv_core #(
  parameter int CH      = 8,
  parameter int OUT_DIM = 16,
  parameter int SHIFT   = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic [15:0] i_data_0,
  output logic [7:0]  o_data,
  output logic        o_valid
);

  localparam int NW    = CH * 9;
  localparam int WC_W  = $clog2(NW);
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;
  localparam int POS_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;

  typedef enum logic {
    LOAD_W = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Control state
  state_t            state_q, state_d;
  logic [WC_W-1:0]   w_cnt_q, w_cnt_d;    // weight beat index (ch*9 + tap)
  logic [1:0]        srow_q, srow_d;      // strip row within a channel
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;  // channel within a group
  logic [POS_W-1:0]  pcol_q, pcol_d;      // pooled output column c
  logic [POS_W-1:0]  prow_q, prow_d;      // pooled output row r
  logic              prime_q, prime_d;    // next group is a priming group
  logic              group_end;
  logic              accept;

  // Pipeline control
  logic              proc_v_q, proc_v_d;        // a channel window is complete
  logic [CH_W-1:0]   proc_ch_q, proc_ch_d;
  logic              proc_last_q, proc_last_d;  // that channel is the last one
  logic              fin_v_q, fin_v_d;          // accumulators hold final sums
  logic              qv_q, qv_d;                // quantised values ready
  logic              mv_q, mv_d;                // pooled maximum ready
  logic              o_valid_q, o_valid_d;
  logic [7:0]        o_data_q, o_data_d;

  // Storage and datapath
  logic signed [7:0]  w_q [NW];
  logic signed [7:0]  w_d [NW];
  logic [7:0]         win_q [CH][4][4];   // [channel][row][col], cols 0..1 retained
  logic [7:0]         win_d [CH][4][4];
  logic signed [23:0] part [4];           // per-channel sums at the 4 positions
  logic signed [23:0] acc_q [4];
  logic signed [23:0] acc_d [4];
  logic [7:0]         qnt_q [4];
  logic [7:0]         qnt_d [4];
  logic [7:0]         max_q, max_d;
  logic [WC_W-1:0]    widx;
  logic [1:0]         pr, pc;

  // Unsigned pixel times signed weight, sign-extended to accumulator width.
  function automatic logic signed [23:0] mul_px(input logic [7:0] px,
                                                input logic signed [7:0] wt);
    logic signed [16:0] pxs;
    logic signed [16:0] wts;
    logic signed [16:0] m;
    pxs = {9'd0, px};
    wts = {{9{wt[7]}}, wt};
    m   = pxs * wts;
    return {{7{m[16]}}, m};
  endfunction

  // ReLU, arithmetic shift, saturate to 8 bits.
  function automatic logic [7:0] quantise(input logic signed [23:0] v);
    logic signed [23:0] s;
    if (v < 24'sd0) begin
      return 8'd0;
    end
    s = v >>> SHIFT;
    if (s > 24'sd255) begin
      return 8'hFF;
    end
    return s[7:0];
  endfunction

  assign accept = i_valid && i_rst;

  // Next-state logic: weight/beat counters, raster position, FSM.
  always_comb begin
    state_d     = state_q;
    w_cnt_d     = w_cnt_q;
    srow_d      = srow_q;
    ch_cnt_d    = ch_cnt_q;
    pcol_d      = pcol_q;
    prow_d      = prow_q;
    prime_d     = prime_q;
    proc_v_d    = 1'b0;
    proc_ch_d   = proc_ch_q;
    proc_last_d = proc_last_q;
    group_end   = 1'b0;
    case (state_q)
      LOAD_W: begin
        if (i_valid) begin
          if (w_cnt_q == WC_W'(NW - 1)) begin
            w_cnt_d  = '0;
            state_d  = STREAM;
            srow_d   = '0;
            ch_cnt_d = '0;
            pcol_d   = '0;
            prow_d   = '0;
            prime_d  = 1'b1;
          end else begin
            w_cnt_d = w_cnt_q + WC_W'(1);
          end
        end
      end
      STREAM: begin
        if (i_valid) begin
          srow_d = srow_q + 2'd1;
          if (srow_q == 2'd3) begin
            // A channel's 4x4 window is complete; compute groups feed the MACs.
            if (!prime_q) begin
              proc_v_d    = 1'b1;
              proc_ch_d   = ch_cnt_q;
              proc_last_d = (ch_cnt_q == CH_W'(CH - 1));
            end
            if (ch_cnt_q == CH_W'(CH - 1)) begin
              ch_cnt_d  = '0;
              group_end = 1'b1;
            end else begin
              ch_cnt_d = ch_cnt_q + CH_W'(1);
            end
          end
          if (group_end) begin
            if (prime_q) begin
              prime_d = 1'b0;
            end else if (pcol_q == POS_W'(OUT_DIM - 1)) begin
              pcol_d  = '0;
              prime_d = 1'b1;
              if (prow_q == POS_W'(OUT_DIM - 1)) begin
                // Frame complete: further beats are next frame's weights.
                prow_d  = '0;
                state_d = LOAD_W;
              end else begin
                prow_d = prow_q + POS_W'(1);
              end
            end else begin
              pcol_d = pcol_q + POS_W'(1);
            end
          end
        end
      end
      default: state_d = LOAD_W;
    endcase
  end

  // Weight store and strip window update; a new strip pushes the previous
  // column pair into the retained slots.
  always_comb begin
    w_d   = w_q;
    win_d = win_q;
    if (accept && state_q == LOAD_W) begin
      w_d[w_cnt_q] = $signed(i_data_0[7:0]);
    end
    if (accept && state_q == STREAM) begin
      win_d[ch_cnt_q][srow_q][0] = win_q[ch_cnt_q][srow_q][2];
      win_d[ch_cnt_q][srow_q][1] = win_q[ch_cnt_q][srow_q][3];
      win_d[ch_cnt_q][srow_q][2] = i_data_0[15:8];
      win_d[ch_cnt_q][srow_q][3] = i_data_0[7:0];
    end
  end

  // 3x3 convolution of one channel's window at the four pooled positions.
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      part[p] = '0;
    end
    widx = '0;
    pr   = '0;
    pc   = '0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        for (int dr = 0; dr < 3; dr++) begin
          for (int dc = 0; dc < 3; dc++) begin
            widx = WC_W'(int'(proc_ch_q) * 9 + dr * 3 + dc);
            pr   = 2'(i + dr);
            pc   = 2'(j + dc);
            part[i*2+j] = part[i*2+j] + mul_px(win_q[proc_ch_q][pr][pc], w_q[widx]);
          end
        end
      end
    end
  end

  // Channel accumulation, quantise, 2x2 max and output register stages.
  always_comb begin
    acc_d     = acc_q;
    qnt_d     = qnt_q;
    max_d     = max_q;
    o_data_d  = o_data_q;
    fin_v_d   = proc_v_q && proc_last_q;
    qv_d      = fin_v_q;
    mv_d      = qv_q;
    o_valid_d = mv_q;
    if (proc_v_q) begin
      for (int p = 0; p < 4; p++) begin
        if (proc_ch_q == '0) begin
          acc_d[p] = part[p];
        end else begin
          acc_d[p] = acc_q[p] + part[p];
        end
      end
    end
    if (fin_v_q) begin
      for (int p = 0; p < 4; p++) begin
        qnt_d[p] = quantise(acc_q[p]);
      end
    end
    if (qv_q) begin
      max_d = qnt_q[0];
      for (int p = 1; p < 4; p++) begin
        if (qnt_q[p] > max_d) begin
          max_d = qnt_q[p];
        end
      end
    end
    if (mv_q) begin
      o_data_d = max_q;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= LOAD_W;
      w_cnt_q   <= '0;
      srow_q    <= '0;
      ch_cnt_q  <= '0;
      pcol_q    <= '0;
      prow_q    <= '0;
      prime_q   <= 1'b1;
      proc_v_q  <= 1'b0;
      fin_v_q   <= 1'b0;
      qv_q      <= 1'b0;
      mv_q      <= 1'b0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      w_cnt_q   <= w_cnt_d;
      srow_q    <= srow_d;
      ch_cnt_q  <= ch_cnt_d;
      pcol_q    <= pcol_d;
      prow_q    <= prow_d;
      prime_q   <= prime_d;
      proc_v_q  <= proc_v_d;
      fin_v_q   <= fin_v_d;
      qv_q      <= qv_d;
      mv_q      <= mv_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
    end
  end

  // Datapath storage; contents are qualified by the valid flags above.
  always_ff @(posedge i_clk) begin
    w_q         <= w_d;
    win_q       <= win_d;
    acc_q       <= acc_d;
    qnt_q       <= qnt_d;
    max_q       <= max_d;
    proc_ch_q   <= proc_ch_d;
    proc_last_q <= proc_last_d;
  end

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;

endmodule

// File: tb/tb_conv_core.sv
// tb_conv_core: drives whole frames (weights then padded image strips)
// into conv_core and compares every cycle against a direct convolution
// model of the padded image.
module tb_conv_core;

  localparam int CH      = 8;
  localparam int OUT_DIM = 16;
  localparam int SHIFT   = 3;
  localparam int PAD     = 34;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = 16'd0;
  logic [7:0]  out_data;
  logic        out_valid;

  always #5 clk = ~clk;

  conv_core #(.CH(CH), .OUT_DIM(OUT_DIM), .SHIFT(SHIFT)) dut (
    .i_clk   (clk),
    .i_rst   (rst_n),
    .i_valid (in_valid),
    .i_data_0(in_data),
    .o_data  (out_data),
    .o_valid (out_valid)
  );

  int   cyc = 0;
  logic rst_at_edge = 1'b0;
  always @(posedge clk) begin
    cyc         <= cyc + 1;
    rst_at_edge <= rst_n;
  end

  // Model state and scoreboard
  int          img [CH][PAD][PAD];
  int          wt  [CH][9];
  logic [7:0]  exp_q[$];
  int          exp_cyc_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_pulse = 0;
  int          n_expected_total = 0;
  logic [7:0]  last_data = 8'd0;
  int          gap_mode = 0;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Pooled output (r,c) computed straight from the padded image.
  function automatic int model_out(input int r, input int c);
    int best;
    int s;
    int q;
    best = 0;
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int ch = 0; ch < CH; ch++)
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              s += img[ch][2*r+i+dr][2*c+j+dc] * wt[ch][dr*3+dc];
        q = (s < 0) ? 0 : (s >> SHIFT);
        if (q > 255) q = 255;
        if (q > best) best = q;
      end
    end
    return best;
  endfunction

  // Image / weight builders
  task automatic fill_img(input int v);
    for (int ch = 0; ch < CH; ch++)
      for (int y = 0; y < PAD; y++)
        for (int x = 0; x < PAD; x++)
          img[ch][y][x] = (y == 0 || x == 0 || y == PAD-1 || x == PAD-1) ? 0 : v;
  endtask

  task automatic fill_img_random();
    fill_img(0);
    for (int ch = 0; ch < CH; ch++)
      for (int y = 1; y < PAD-1; y++)
        for (int x = 1; x < PAD-1; x++)
          img[ch][y][x] = $urandom_range(0, 255);
  endtask

  task automatic set_weights(input int centre, input int other);
    for (int ch = 0; ch < CH; ch++)
      for (int t = 0; t < 9; t++)
        wt[ch][t] = (t == 4) ? centre : other;
  endtask

  task automatic set_weights_random();
    for (int ch = 0; ch < CH; ch++)
      for (int t = 0; t < 9; t++)
        wt[ch][t] = int'($urandom_range(0, 255)) - 128;
  endtask

  // Driver tasks
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic drive_beat(input logic [15:0] d, output int acc_cyc);
    int g;
    int p;
    g = 0;
    if (gap_mode != 0) begin
      p = $urandom_range(0, 99);
      if (p < 20) g = 1;
      else if (p < 30) g = 5;
    end
    repeat (g) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = 16'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    acc_cyc  = cyc + 1;
  endtask

  task automatic load_weights();
    int a;
    for (int ch = 0; ch < CH; ch++)
      for (int t = 0; t < 9; t++)
        drive_beat({8'($urandom), 8'(wt[ch][t])}, a);
  endtask

  task automatic send_group(input int r, input int col0, input int compute, input int c);
    int a;
    a = 0;
    for (int ch = 0; ch < CH; ch++)
      for (int k = 0; k < 4; k++)
        drive_beat({8'(img[ch][2*r+k][col0]), 8'(img[ch][2*r+k][col0+1])}, a);
    if (compute != 0) begin
      exp_q.push_back(8'(model_out(r, c)));
      exp_cyc_q.push_back(a + 4);
      n_expected_total++;
    end
  endtask

  task automatic run_frame();
    load_weights();
    for (int r = 0; r < OUT_DIM; r++)
      for (int c = 0; c < OUT_DIM; c++) begin
        if (c == 0) send_group(r, 0, 0, 0);
        send_group(r, 2*c+2, 1, c);
      end
  endtask

  // Compare process: every cycle out of reset the DUT must either pulse
  // exactly when expected with the model value, or stay quiet and hold.
  always @(negedge clk) begin
    if (!rst_at_edge) begin
      check("reset_o_valid", int'(out_valid), 0);
      check("reset_o_data", int'(out_data), 0);
      last_data = 8'd0;
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
      check("o_valid_on_time", int'(out_valid), 1);
      if (out_valid) begin
        check("o_data", int'(out_data), int'(exp_q[0]));
        last_data = out_data;
        n_pulse++;
      end
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
    end else begin
      check("no_spurious_o_valid", int'(out_valid), 0);
      if (out_valid) begin
        n_pulse++;
        last_data = out_data;
      end else begin
        check("o_data_hold", int'(out_data), int'(last_data));
      end
    end
  end

  // Stimulus sequence
  initial begin
    int a;
    // Reset held for two edges with i_valid high.
    rst_n    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'hA5A5;
    repeat (2) @(negedge clk);
    check("reset_direct_o_valid", int'(out_valid), 0);
    check("reset_direct_o_data", int'(out_data), 0);
    rst_n    = 1'b1;
    in_valid = 1'b0;

    // Abandoned frame: reset in the middle of a compute group.
    gap_mode = 0;
    fill_img_random();
    set_weights_random();
    load_weights();
    send_group(0, 0, 0, 0);
    for (int k = 0; k < 20; k++) drive_beat(16'($urandom), a);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(8);

    // Centre-tap identity.
    fill_img(40);
    set_weights(1, 0);
    check("pin_centre_00", model_out(0, 0), 40);
    check("pin_centre_ff", model_out(15, 15), 40);
    run_frame();

    // Saturation.
    fill_img(255);
    set_weights(127, 127);
    check("pin_saturate", model_out(0, 0), 255);
    run_frame();

    // ReLU.
    fill_img(100);
    set_weights(-1, -1);
    check("pin_relu", model_out(7, 7), 0);
    run_frame();

    // Max-pool selectivity: one pixel in channel 0.
    fill_img(0);
    img[0][2][2] = 200;
    set_weights(1, 0);
    check("pin_pool_00", model_out(0, 0), 25);
    check("pin_pool_01", model_out(0, 1), 0);
    check("pin_pool_10", model_out(1, 0), 0);
    run_frame();

    // Random data with 1- and 5-cycle valid gaps.
    gap_mode = 1;
    fill_img_random();
    set_weights_random();
    run_frame();

    // Random data back-to-back.
    gap_mode = 0;
    fill_img_random();
    set_weights_random();
    run_frame();

    idle(12);
    check("pulse_count", n_pulse, n_expected_total);
    check("exp_queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
